// File: rtl/mips_ctrl_alu.sv
// mips_ctrl_alu
// Main decode, ALU control and 32-bit ALU for the 5-stage MIPS pipeline.
// Everything is combinational up to a single output register stage, so
// outputs appear one clock after the inputs.
//
// Optional feature macro: MIPS_ALU_SHIFT_EN
//   defined   : funct 000000 / 000010 decode to sll / srl and the shifter is built.
//   undefined : those funct codes decode to 1111 and produce result 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears every output
//   stall      hold all output registers (takes priority over flush)
//   flush      load a bubble: control outputs and alu_ctl go to 0,
//              result and zero still update
//   op_code    instruction[31:26]
//   funct      instruction[5:0]
//   shamt      instruction[10:6]
//   in1, in2   ALU operands A and B
//   reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
//   alu_op     registered main-decode outputs
//   alu_ctl    registered ALU operation code
//   result     registered ALU result
//   zero       registered flag, set when the ALU result is 0
module mips_ctrl_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  op_code,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        reg_dst,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic [3:0]  alu_ctl,
  output logic [31:0] result,
  output logic        zero
);

  // Opcodes
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;

  // R-type funct codes
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;
`ifdef MIPS_ALU_SHIFT_EN
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
`endif

  // ALU operation codes
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluBad = 4'b1111;
`ifdef MIPS_ALU_SHIFT_EN
  localparam logic [3:0] AluSll = 4'b0011;
  localparam logic [3:0] AluSrl = 4'b0100;
`endif

  logic        reg_dst_d;
  logic        branch_d;
  logic        mem_read_d;
  logic        mem_to_reg_d;
  logic        mem_write_d;
  logic        alu_src_d;
  logic        reg_write_d;
  logic [1:0]  alu_op_d;
  logic [3:0]  alu_ctl_d;
  logic [31:0] result_d;
  logic        zero_d;

  // Main decode
  always_comb begin
    reg_dst_d    = 1'b0;
    branch_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    alu_op_d     = 2'b00;
    case (op_code)
      OpRType: begin
        reg_dst_d   = 1'b1;
        alu_op_d    = 2'b10;
        reg_write_d = 1'b1;
      end
      OpLw: begin
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_src_d    = 1'b1;
        reg_write_d  = 1'b1;
      end
      OpSw: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OpBeq: begin
        branch_d = 1'b1;
        alu_op_d = 2'b01;
      end
      OpAddi: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control; ALUOp 11 is never produced by the decoder but maps to add.
  always_comb begin
    alu_ctl_d = AluAdd;
    case (alu_op_d)
      2'b00: alu_ctl_d = AluAdd;
      2'b01: alu_ctl_d = AluSub;
      2'b11: alu_ctl_d = AluAdd;
      2'b10: begin
        case (funct)
          FnAdd:   alu_ctl_d = AluAdd;
          FnSub:   alu_ctl_d = AluSub;
          FnAnd:   alu_ctl_d = AluAnd;
          FnOr:    alu_ctl_d = AluOr;
          FnNor:   alu_ctl_d = AluNor;
          FnSlt:   alu_ctl_d = AluSlt;
`ifdef MIPS_ALU_SHIFT_EN
          FnSll:   alu_ctl_d = AluSll;
          FnSrl:   alu_ctl_d = AluSrl;
`endif
          default: alu_ctl_d = AluBad;
        endcase
      end
      default: alu_ctl_d = AluAdd;
    endcase
  end

  // ALU datapath; shifts operate on the rt path (in2) by shamt.
  always_comb begin
    result_d = 32'd0;
    case (alu_ctl_d)
      AluAnd:  result_d = in1 & in2;
      AluOr:   result_d = in1 | in2;
      AluAdd:  result_d = in1 + in2;
      AluSub:  result_d = in1 - in2;
      AluSlt:  result_d = {31'd0, $signed(in1) < $signed(in2)};
      AluNor:  result_d = ~(in1 | in2);
`ifdef MIPS_ALU_SHIFT_EN
      AluSll:  result_d = in2 << shamt;
      AluSrl:  result_d = in2 >> shamt;
`endif
      default: result_d = 32'd0;
    endcase
    zero_d = (result_d == 32'd0);
  end

`ifndef MIPS_ALU_SHIFT_EN
  // shamt only feeds the shifter.
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  // Output register: rst > stall > flush > normal capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_dst    <= 1'b0;
      branch     <= 1'b0;
      mem_read   <= 1'b0;
      mem_to_reg <= 1'b0;
      mem_write  <= 1'b0;
      alu_src    <= 1'b0;
      reg_write  <= 1'b0;
      alu_op     <= 2'b00;
      alu_ctl    <= 4'b0000;
      result     <= 32'd0;
      zero       <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        reg_dst    <= 1'b0;
        branch     <= 1'b0;
        mem_read   <= 1'b0;
        mem_to_reg <= 1'b0;
        mem_write  <= 1'b0;
        alu_src    <= 1'b0;
        reg_write  <= 1'b0;
        alu_op     <= 2'b00;
        alu_ctl    <= 4'b0000;
      end else begin
        reg_dst    <= reg_dst_d;
        branch     <= branch_d;
        mem_read   <= mem_read_d;
        mem_to_reg <= mem_to_reg_d;
        mem_write  <= mem_write_d;
        alu_src    <= alu_src_d;
        reg_write  <= reg_write_d;
        alu_op     <= alu_op_d;
        alu_ctl    <= alu_ctl_d;
      end
      // A bubble still carries the ALU result so forwarding paths stay defined.
      result <= result_d;
      zero   <= zero_d;
    end
  end

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// Self-checking bench for mips_ctrl_alu using directed vectors.
module tb_mips_ctrl_alu;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [5:0]  op_code;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        reg_dst;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctl;
  logic [31:0] result;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  // Control vector order: RegDst, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite
  localparam logic [8:0] CtlR    = 9'b1_0_0_0_10_0_0_1;
  localparam logic [8:0] CtlLw   = 9'b0_0_1_1_00_0_1_1;
  localparam logic [8:0] CtlSw   = 9'b0_0_0_0_00_1_1_0;
  localparam logic [8:0] CtlBeq  = 9'b0_1_0_0_01_0_0_0;
  localparam logic [8:0] CtlAddi = 9'b0_0_0_0_00_0_1_1;
  localparam logic [8:0] CtlNone = 9'b0;

  mips_ctrl_alu dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .op_code    (op_code),
    .funct      (funct),
    .shamt      (shamt),
    .in1        (in1),
    .in2        (in2),
    .reg_dst    (reg_dst),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .alu_ctl    (alu_ctl),
    .result     (result),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl_obs();
    return {reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write};
  endfunction

  function automatic logic [45:0] all_obs();
    return {ctl_obs(), alu_ctl, result, zero};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    op_code = op;
    funct   = fn;
    shamt   = sh;
    in1     = a;
    in2     = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(6'b000000, 6'b100000, 5'd0, 32'd5, 32'd7);
    step();
    checks++;
    if (all_obs() !== 46'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", all_obs(), 46'd0);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (result !== 32'd12 || ctl_obs() !== CtlR) begin
      failures++;
      $display("FAIL reset_first_capture result=%h ctl=%b exp result=0000000c ctl=%b",
               result, ctl_obs(), CtlR);
    end
  endtask

  task automatic test_radd();
    drive(6'b000000, 6'b100000, 5'd0, 32'd5, 32'd7);
    step();
    checks++;
    if (result !== 32'd12 || zero !== 1'b0 || alu_ctl !== 4'b0010) begin
      failures++;
      $display("FAIL radd_alu result=%h zero=%b ctl=%b exp 0000000c 0 0010", result, zero, alu_ctl);
    end
    checks++;
    if (ctl_obs() !== CtlR) begin
      failures++;
      $display("FAIL radd_ctl got=%b exp=%b", ctl_obs(), CtlR);
    end
  endtask

  task automatic test_logic_ops();
    drive(6'b000000, 6'b100010, 5'd0, 32'd3, 32'd5);      // sub
    step();
    checks++;
    if (result !== 32'hFFFF_FFFE || alu_ctl !== 4'b0110) begin
      failures++;
      $display("FAIL rsub result=%h ctl=%b exp fffffffe 0110", result, alu_ctl);
    end
    drive(6'b000000, 6'b100100, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00); // and
    step();
    checks++;
    if (result !== 32'h00F0_1200 || alu_ctl !== 4'b0000) begin
      failures++;
      $display("FAIL rand result=%h ctl=%b exp 00f01200 0000", result, alu_ctl);
    end
    drive(6'b000000, 6'b100101, 5'd0, 32'hF0F0_0000, 32'h0000_000F); // or
    step();
    checks++;
    if (result !== 32'hF0F0_000F || alu_ctl !== 4'b0001) begin
      failures++;
      $display("FAIL ror result=%h ctl=%b exp f0f0000f 0001", result, alu_ctl);
    end
    drive(6'b000000, 6'b100111, 5'd0, 32'hFFFF_0000, 32'h0000_FFF0); // nor
    step();
    checks++;
    if (result !== 32'h0000_000F || alu_ctl !== 4'b1100 || zero !== 1'b0) begin
      failures++;
      $display("FAIL rnor result=%h ctl=%b zero=%b exp 0000000f 1100 0", result, alu_ctl, zero);
    end
    drive(6'b000000, 6'b111111, 5'd0, 32'd9, 32'd9);      // unknown funct
    step();
    checks++;
    if (result !== 32'd0 || alu_ctl !== 4'b1111 || zero !== 1'b1) begin
      failures++;
      $display("FAIL rbad result=%h ctl=%b zero=%b exp 00000000 1111 1", result, alu_ctl, zero);
    end
  endtask

  task automatic test_beq();
    drive(6'b000100, 6'b000000, 5'd0, 32'h1234, 32'h1234);
    step();
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || alu_ctl !== 4'b0110 || ctl_obs() !== CtlBeq) begin
      failures++;
      $display("FAIL beq_equal result=%h zero=%b ctl=%b dec=%b exp 00000000 1 0110 %b",
               result, zero, alu_ctl, ctl_obs(), CtlBeq);
    end
    drive(6'b000100, 6'b000000, 5'd0, 32'h1234, 32'h1235);
    step();
    checks++;
    if (result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      failures++;
      $display("FAIL beq_unequal result=%h zero=%b exp ffffffff 0", result, zero);
    end
  endtask

  task automatic test_slt();
    drive(6'b000000, 6'b101010, 5'd0, 32'hFFFF_FFFB, 32'd3);
    step();
    checks++;
    if (result !== 32'd1 || zero !== 1'b0 || alu_ctl !== 4'b0111) begin
      failures++;
      $display("FAIL slt_neg result=%h zero=%b ctl=%b exp 00000001 0 0111", result, zero, alu_ctl);
    end
    drive(6'b000000, 6'b101010, 5'd0, 32'd3, 32'hFFFF_FFFB);
    step();
    checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL slt_swapped result=%h zero=%b exp 00000000 1", result, zero);
    end
  endtask

  task automatic test_mem_ops();
    drive(6'b101011, 6'b101010, 5'd0, 32'd200, 32'd4);    // sw, funct ignored
    step();
    checks++;
    if (result !== 32'd204 || alu_ctl !== 4'b0010 || ctl_obs() !== CtlSw) begin
      failures++;
      $display("FAIL sw result=%h ctl=%b dec=%b exp 000000cc 0010 %b",
               result, alu_ctl, ctl_obs(), CtlSw);
    end
    drive(6'b001000, 6'b000000, 5'd0, 32'hFFFF_FFFF, 32'd1); // addi wraps
    step();
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || ctl_obs() !== CtlAddi) begin
      failures++;
      $display("FAIL addi_wrap result=%h zero=%b dec=%b exp 00000000 1 %b",
               result, zero, ctl_obs(), CtlAddi);
    end
    drive(6'b111111, 6'b100010, 5'd0, 32'd1, 32'd2);      // unknown opcode -> add
    step();
    checks++;
    if (ctl_obs() !== CtlNone || alu_ctl !== 4'b0010 || result !== 32'd3) begin
      failures++;
      $display("FAIL bad_opcode dec=%b ctl=%b result=%h exp %b 0010 00000003",
               ctl_obs(), alu_ctl, result, CtlNone);
    end
  endtask

  task automatic test_flush_stall();
    drive(6'b100011, 6'b000000, 5'd0, 32'd100, 32'd8);
    step();
    checks++;
    if (result !== 32'd108 || ctl_obs() !== CtlLw || alu_ctl !== 4'b0010) begin
      failures++;
      $display("FAIL lw result=%h dec=%b ctl=%b exp 0000006c %b 0010",
               result, ctl_obs(), alu_ctl, CtlLw);
    end
    flush = 1'b1;
    step();
    checks++;
    if (result !== 32'd108 || zero !== 1'b0 || ctl_obs() !== CtlNone || alu_ctl !== 4'b0000) begin
      failures++;
      $display("FAIL flush result=%h zero=%b dec=%b ctl=%b exp 0000006c 0 %b 0000",
               result, zero, ctl_obs(), alu_ctl, CtlNone);
    end
    flush = 1'b0;
    step();                                              // reload lw
    stall = 1'b1;
    flush = 1'b1;
    drive(6'b000100, 6'b000000, 5'd0, 32'd7, 32'd7);
    step();
    step();
    checks++;
    if (result !== 32'd108 || zero !== 1'b0 || ctl_obs() !== CtlLw || alu_ctl !== 4'b0010) begin
      failures++;
      $display("FAIL stall_hold result=%h zero=%b dec=%b ctl=%b exp 0000006c 0 %b 0010",
               result, zero, ctl_obs(), alu_ctl, CtlLw);
    end
    stall = 1'b0;
    flush = 1'b0;
    step();
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || ctl_obs() !== CtlBeq) begin
      failures++;
      $display("FAIL stall_release result=%h zero=%b dec=%b exp 00000000 1 %b",
               result, zero, ctl_obs(), CtlBeq);
    end
  endtask

  task automatic test_mid_reset();
    drive(6'b000000, 6'b100000, 5'd0, 32'd5, 32'd7);
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_obs() !== 46'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", all_obs(), 46'd0);
    end
    step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (all_obs() !== 46'd0) begin
      failures++;
      $display("FAIL reset_no_early_capture got=%h exp=%h", all_obs(), 46'd0);
    end
    step();
    checks++;
    if (result !== 32'd12 || ctl_obs() !== CtlR || alu_ctl !== 4'b0010) begin
      failures++;
      $display("FAIL reset_recapture result=%h dec=%b ctl=%b exp 0000000c %b 0010",
               result, ctl_obs(), alu_ctl, CtlR);
    end
  endtask

  task automatic test_shift();
    drive(6'b000000, 6'b000000, 5'd31, 32'hDEAD_BEEF, 32'd1);
    step();
    checks++;
`ifdef MIPS_ALU_SHIFT_EN
    if (result !== 32'h8000_0000 || alu_ctl !== 4'b0011 || zero !== 1'b0) begin
      failures++;
      $display("FAIL sll result=%h ctl=%b zero=%b exp 80000000 0011 0", result, alu_ctl, zero);
    end
`else
    if (result !== 32'd0 || alu_ctl !== 4'b1111 || zero !== 1'b1) begin
      failures++;
      $display("FAIL sll_disabled result=%h ctl=%b zero=%b exp 00000000 1111 1",
               result, alu_ctl, zero);
    end
`endif
    drive(6'b000000, 6'b000010, 5'd4, 32'd0, 32'h8000_0000);
    step();
    checks++;
`ifdef MIPS_ALU_SHIFT_EN
    if (result !== 32'h0800_0000 || alu_ctl !== 4'b0100) begin
      failures++;
      $display("FAIL srl result=%h ctl=%b exp 08000000 0100", result, alu_ctl);
    end
`else
    if (result !== 32'd0 || alu_ctl !== 4'b1111 || zero !== 1'b1) begin
      failures++;
      $display("FAIL srl_disabled result=%h ctl=%b zero=%b exp 00000000 1111 1",
               result, alu_ctl, zero);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_radd();
    test_logic_ops();
    test_beq();
    test_slt();
    test_mem_ops();
    test_flush_stall();
    test_mid_reset();
    test_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
